// File: rtl/div_seq.sv
// div_seq -- sequential 32-bit restoring divider for MIPS div / divu.
//
// Operands are accepted in IDLE when start is high. Their magnitudes are
// divided with one restoring step per clock over 32 cycles. FIX then
// applies the sign corrections, and DONE pulses done for one cycle.
// Division truncates toward zero, and the remainder takes the sign of
// the dividend.
//
// Optional feature: define DIV_UNSIGNED_EN to add the is_unsigned port.
// It selects divu, which skips all sign handling. Without the macro every
// operation is signed.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   start        request a division (sampled only in IDLE)
//   dividend     rs operand, captured on the accepting edge
//   divisor      rt operand, captured on the accepting edge
//   is_unsigned  divu select (only with DIV_UNSIGNED_EN)
//   busy         high while the division is in progress, excluding done
//   done         one-cycle pulse; hi, lo and div_zero are valid
//   div_zero     divisor was zero; held until the next accepted start
//   hi           remainder, held between operations
//   lo           quotient, held between operations
module div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
`ifdef DIV_UNSIGNED_EN
  input  logic        is_unsigned,
`endif
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state;
  logic [31:0] quo;        // dividend magnitude shifting out, quotient shifting in
  logic [31:0] dvsr;       // divisor magnitude
  logic [31:0] rem;        // partial remainder, always < dvsr between steps
  logic [5:0]  cnt;
  logic        neg_q;      // quotient must be negated
  logic        neg_r;      // remainder must be negated

  logic        uns;
`ifdef DIV_UNSIGNED_EN
  assign uns = is_unsigned;
`else
  assign uns = 1'b0;
`endif

  // Operand sign and magnitude. Negating 0x80000000 wraps back to
  // 0x80000000, which is the correct unsigned magnitude.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign a_neg = dividend[31] & ~uns;
  assign b_neg = divisor[31]  & ~uns;
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor  : divisor;

  // One restoring step. The shifted remainder needs 33 bits. It is
  // below 2*dvsr, so the difference always fits back into 32 bits.
  logic [32:0] rem_sh;
  logic [31:0] rem_sub;
  logic [31:0] rem_next;
  logic        fits;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    rem_sh   = {rem, quo[31]};
    fits     = rem_sh >= {1'b0, dvsr};
    rem_sub  = rem_sh[31:0] - dvsr;
    rem_next = rem_sh[31:0];
    if (fits) rem_next = rem_sub;
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values, matching the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      quo      <= '0;
      dvsr     <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_zero <= 1'b0;
            if (divisor == 32'd0) begin
              // Skip the loop entirely; hi and lo keep their old values.
              div_zero <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              quo   <= a_mag;
              dvsr  <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              rem   <= '0;
              cnt   <= 6'd32;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem <= rem_next;
          quo <= {quo[30:0], fits};
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= FIX;
        end
        FIX: begin
          lo    <= neg_q ? -quo : quo;
          hi    <= neg_r ? -rem : rem;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq -- self-checking bench for div_seq.
// Expected results come from a behavioural model built on 64-bit
// arithmetic. They are pushed to a scoreboard queue when an operation is
// started and popped when done is observed. Outputs are sampled on the
// falling edge, and inputs are driven on the falling edge.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
`ifdef DIV_UNSIGNED_EN
  logic        is_unsigned;
`endif
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  div_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
`ifdef DIV_UNSIGNED_EN
    .is_unsigned (is_unsigned),
`endif
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          busy_bad;
  } obs_t;

  exp_t        scoreboard[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mhi = '0;   // model's view of the held hi/lo registers
  logic [31:0] mlo = '0;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic uns);
    exp_t   e;
    longint sa, sd, q, r;
    if (b == 32'd0) begin
      e.hi = mhi; e.lo = mlo; e.dz = 1'b1; e.lat = 1;
    end else begin
      if (uns) begin
        sa = longint'({32'd0, a});
        sd = longint'({32'd0, b});
      end else begin
        sa = longint'($signed(a));
        sd = longint'($signed(b));
      end
      q = sa / sd;
      r = sa % sd;
      e.lo = q[31:0]; e.hi = r[31:0]; e.dz = 1'b0; e.lat = 34;
    end
    return e;
  endfunction

  // Starts one operation and waits for done. With early set, start is
  // raised in the current (done) cycle and held one more cycle. Only the
  // second cycle may be accepted, and latency is counted from it.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic uns, input bit early,
                       output obs_t o, output exp_t e);
    exp_t x;
    x = model(a, b, uns);
    scoreboard.push_back(x);
    if (!x.dz) begin mhi = x.hi; mlo = x.lo; end
    if (!early) @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
`ifdef DIV_UNSIGNED_EN
    is_unsigned = uns;
`endif
    if (early) begin
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
`ifdef DIV_UNSIGNED_EN
    is_unsigned = ~uns;
`endif
    o.hi = '0; o.lo = '0; o.dz = 1'b0; o.lat = -1; o.busy_bad = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy !== (x.dz ? 1'b0 : (k <= 33))) o.busy_bad++;
      if (done === 1'b1) begin
        o.lat = k; o.hi = hi; o.lo = lo; o.dz = div_zero;
        break;
      end
    end
    e = scoreboard.pop_front();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef DIV_UNSIGNED_EN
    is_unsigned = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h, want all zero",
               busy, done, div_zero, hi, lo);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    obs_t o; exp_t e;
    do_op(32'd100, 32'd7, 1'b0, 1'b0, o, e);
    n_cmp++;
    if ({o.hi, o.lo, o.dz} !== {e.hi, e.lo, e.dz} || e.lo !== 32'd14 || e.hi !== 32'd2) begin
      n_bad++;
      $display("FAIL basic_100_7: hi=%h lo=%h dz=%b, want hi=00000002 lo=0000000e dz=0",
               o.hi, o.lo, o.dz);
    end
    n_cmp++;
    if (o.lat !== e.lat) begin
      n_bad++; $display("FAIL basic_latency: got %0d, want %0d", o.lat, e.lat);
    end
    n_cmp++;
    if (o.busy_bad !== 0) begin
      n_bad++; $display("FAIL basic_busy: %0d wrong busy cycles, want 0", o.busy_bad);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL done_pulse: done=%b in cycle after done, want 0", done);
    end
  endtask

  task automatic test_signs;
    logic [31:0] ta[6] = '{32'hFFFFFFF9, 32'd7,        32'hFFFFFFF9,
                           32'd0,        32'h80000000, 32'h80000000};
    logic [31:0] tb[6] = '{32'd2,        32'hFFFFFFFE, 32'hFFFFFFFE,
                           32'd5,        32'hFFFFFFFF, 32'd1};
    obs_t o; exp_t e;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], 1'b0, 1'b0, o, e);
      n_cmp++;
      if ({o.hi, o.lo, o.dz} !== {e.hi, e.lo, e.dz} || o.lat !== e.lat) begin
        n_bad++;
        $display("FAIL signs[%0d] %h/%h: hi=%h lo=%h dz=%b lat=%0d, want hi=%h lo=%h dz=%b lat=%0d",
                 i, ta[i], tb[i], o.hi, o.lo, o.dz, o.lat, e.hi, e.lo, e.dz, e.lat);
      end
    end
  endtask

  task automatic test_div_zero;
    obs_t o; exp_t e;
    do_op(32'd100, 32'd7, 1'b0, 1'b0, o, e);
    do_op(32'd5, 32'd0, 1'b0, 1'b0, o, e);
    n_cmp++;
    if ({o.hi, o.lo, o.dz} !== {32'd2, 32'd14, 1'b1} || {e.hi, e.lo, e.dz} !== {32'd2, 32'd14, 1'b1}) begin
      n_bad++;
      $display("FAIL div_zero_result: hi=%h lo=%h dz=%b, want hi=00000002 lo=0000000e dz=1",
               o.hi, o.lo, o.dz);
    end
    n_cmp++;
    if (o.lat !== 1 || o.busy_bad !== 0) begin
      n_bad++;
      $display("FAIL div_zero_timing: lat=%0d busy_bad=%0d, want lat=1 busy_bad=0",
               o.lat, o.busy_bad);
    end
    @(negedge clk);
    n_cmp++;
    if (div_zero !== 1'b1) begin
      n_bad++; $display("FAIL div_zero_hold: div_zero=%b after done, want 1", div_zero);
    end
    do_op(32'd9, 32'd3, 1'b0, 1'b0, o, e);
    n_cmp++;
    if ({o.hi, o.lo, o.dz} !== {e.hi, e.lo, e.dz}) begin
      n_bad++;
      $display("FAIL div_zero_clear: hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=%b",
               o.hi, o.lo, o.dz, e.hi, e.lo, e.dz);
    end
  endtask

  task automatic test_back_to_back;
    obs_t o; exp_t e;
    do_op(32'd50, 32'd5, 1'b0, 1'b0, o, e);
    // Start raised during the done cycle must be ignored.
    do_op(32'd1000, 32'hFFFFFFFD, 1'b0, 1'b1, o, e);
    n_cmp++;
    if ({o.hi, o.lo, o.dz} !== {e.hi, e.lo, e.dz} || o.lat !== e.lat || o.busy_bad !== 0) begin
      n_bad++;
      $display("FAIL back_to_back: hi=%h lo=%h lat=%0d busy_bad=%0d, want hi=%h lo=%h lat=%0d busy_bad=0",
               o.hi, o.lo, o.lat, o.busy_bad, e.hi, e.lo, e.lat);
    end
  endtask

  task automatic test_abort;
    obs_t o; exp_t e;
    int   seen;
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen  = 0;
    // Values driven at the falling edge of cycle c are sampled at the end of cycle c.
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
      if (c == 11) begin
        n_cmp++;
        if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
          n_bad++;
          $display("FAIL abort_outputs: busy=%b done=%b dz=%b hi=%h lo=%h, want all zero",
                   busy, done, div_zero, hi, lo);
        end
      end
      start = (c >= 5 && c <= 8);
      reset = (c == 10);
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL abort_no_done: done seen %0d times, want 0", seen);
    end
    mhi = '0;
    mlo = '0;
    do_op(32'd100, 32'd7, 1'b0, 1'b0, o, e);
    n_cmp++;
    if ({o.hi, o.lo, o.dz} !== {e.hi, e.lo, e.dz} || o.lat !== 34 || o.busy_bad !== 0) begin
      n_bad++;
      $display("FAIL abort_restart: hi=%h lo=%h lat=%0d busy_bad=%0d, want hi=%h lo=%h lat=34 busy_bad=0",
               o.hi, o.lo, o.lat, o.busy_bad, e.hi, e.lo);
    end
  endtask

  task automatic test_random;
    obs_t        o; exp_t e;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) b = '0;
      do_op(a, b, 1'b0, 1'b0, o, e);
      n_cmp++;
      if ({o.hi, o.lo, o.dz} !== {e.hi, e.lo, e.dz} || o.lat !== e.lat) begin
        n_bad++;
        $display("FAIL random[%0d] %h/%h: hi=%h lo=%h dz=%b lat=%0d, want hi=%h lo=%h dz=%b lat=%0d",
                 i, a, b, o.hi, o.lo, o.dz, o.lat, e.hi, e.lo, e.dz, e.lat);
      end
    end
  endtask

`ifdef DIV_UNSIGNED_EN
  task automatic test_unsigned;
    obs_t o; exp_t e;
    do_op(32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, o, e);
    n_cmp++;
    if ({o.hi, o.lo, o.dz} !== {32'd1, 32'h7FFFFFFF, 1'b0}) begin
      n_bad++;
      $display("FAIL divu: hi=%h lo=%h dz=%b, want hi=00000001 lo=7fffffff dz=0", o.hi, o.lo, o.dz);
    end
    do_op(32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, o, e);
    n_cmp++;
    if ({o.hi, o.lo, o.dz} !== {32'hFFFFFFFF, 32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL div_signed_same_ops: hi=%h lo=%h dz=%b, want hi=ffffffff lo=00000000 dz=0",
               o.hi, o.lo, o.dz);
    end
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, o, e);
    n_cmp++;
    if ({o.hi, o.lo, o.dz} !== {e.hi, e.lo, e.dz}) begin
      n_bad++;
      $display("FAIL divu_big: hi=%h lo=%h, want hi=%h lo=%h", o.hi, o.lo, e.hi, e.lo);
    end
  endtask
`endif

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_back_to_back();
    test_abort();
    test_random();
`ifdef DIV_UNSIGNED_EN
    test_unsigned();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
